// File: rtl/seg_scan_driver_pkg.sv
// seg_pkg: special digit codes and active-low glyph constants for the seven-segment scanner.
package seg_pkg;
  localparam logic [3:0] CODE_MINUS  = 4'd10;
  localparam logic [3:0] CODE_BLANK  = 4'd11;
  localparam logic [6:0] GLYPH_MINUS = 7'h3F;
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;
  localparam logic [7:0] SEG_OFF     = 8'hFF;

  function automatic logic [6:0] hex_glyph(input logic [3:0] code);
    case (code)
      4'h0: hex_glyph = 7'h40;
      4'h1: hex_glyph = 7'h79;
      4'h2: hex_glyph = 7'h24;
      4'h3: hex_glyph = 7'h30;
      4'h4: hex_glyph = 7'h19;
      4'h5: hex_glyph = 7'h12;
      4'h6: hex_glyph = 7'h02;
      4'h7: hex_glyph = 7'h78;
      4'h8: hex_glyph = 7'h00;
      4'h9: hex_glyph = 7'h10;
      4'hA: hex_glyph = 7'h08;
      4'hB: hex_glyph = 7'h03;
      4'hC: hex_glyph = 7'h46;
      4'hD: hex_glyph = 7'h21;
      4'hE: hex_glyph = 7'h06;
      default: hex_glyph = 7'h0E;
    endcase
  endfunction
endpackage

// File: rtl/seg_scan_driver_if.sv
// seg_scan_driver_if: CPU-side load port carrying packed digit nibbles, dots and display mode.
interface seg_scan_driver_if #(parameter int DIGITS = 8);
  logic                  load;
  logic [4*DIGITS-1:0]   data_in;
  logic [DIGITS-1:0]     dot_in;
  logic                  hex_mode;
  modport master (output load, data_in, dot_in, hex_mode);
  modport slave  (input  load, data_in, dot_in, hex_mode);
endinterface

// File: rtl/seg_scan_driver_glyph.sv
// seg_glyph: maps a digit code plus mode, dot and blank flag to active-low {dp,g..a}.
module seg_glyph
  import seg_pkg::*;
(
  input  logic [3:0] code_i,
  input  logic       hex_i,
  input  logic       dot_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);
  logic [6:0] g;
  always_comb
    g = (hex_i || code_i < 4'd10) ? hex_glyph(code_i) :
        code_i == CODE_MINUS      ? GLYPH_MINUS :
        code_i == CODE_BLANK      ? GLYPH_BLANK : hex_glyph(4'd0);
  assign seg_o = blank_i ? SEG_OFF : {~dot_i, g};
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: double-buffered multiplexed 7-seg scanner; SEG_LZ_SUPPRESS_EN enables leading-zero blanking.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS  = 8,
  parameter int CLK_DIV = 50000,
  parameter int DEAD    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  seg_scan_driver_if.slave  bus,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              frame_done
);
  localparam int PW = $clog2(CLK_DIV);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;

  logic [PW-1:0]       presc_q, presc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] pend_data_q, act_data_q, act_data_d;
  logic [DIGITS-1:0]   pend_dot_q, act_dot_q, act_dot_d, blank_q, blank_d;
  logic                pend_hex_q, act_hex_q, act_hex_d;
  logic                pend_valid_q, pend_valid_d, shown_q;
  logic [7:0]          seg_q, seg_d, glyph;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                slot_end, wrap, commit, dark;

  assign slot_end = presc_q == PW'(CLK_DIV - 1);
  assign wrap     = slot_end && idx_q == IW'(DIGITS - 1);
  assign commit   = wrap && (bus.load || pend_valid_q);
  assign presc_d  = slot_end ? '0 : presc_q + 1'b1;
  assign idx_d    = wrap ? '0 : slot_end ? idx_q + 1'b1 : idx_q;
  assign pend_valid_d = wrap ? 1'b0 : bus.load ? 1'b1 : pend_valid_q;
  // a load landing on the frame boundary bypasses the pending buffer
  assign act_data_d = bus.load ? bus.data_in  : pend_data_q;
  assign act_dot_d  = bus.load ? bus.dot_in   : pend_dot_q;
  assign act_hex_d  = bus.load ? bus.hex_mode : pend_hex_q;

`ifdef SEG_LZ_SUPPRESS_EN
  always_comb begin
    logic keep;
    keep    = 1'b0;
    blank_d = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      keep       = keep | (act_data_d[4*i +: 4] != 4'd0) | act_dot_d[i];
      blank_d[i] = ~keep & ~act_hex_d;
    end
  end
`else
  assign blank_d = '0;
`endif

  seg_glyph u_glyph (
    .code_i  (act_data_q[4*int'(idx_q) +: 4]),
    .hex_i   (act_hex_q),
    .dot_i   (act_dot_q[idx_q]),
    .blank_i (blank_q[idx_q]),
    .seg_o   (glyph)
  );

  assign dark  = !shown_q || presc_q < PW'(DEAD);
  assign seg_d = dark ? SEG_OFF : glyph;
  assign an_d  = dark ? '1 : ~(DIGITS'(1) << idx_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= '0;
      pend_data_q  <= '0;
      pend_dot_q   <= '0;
      pend_hex_q   <= 1'b0;
      pend_valid_q <= 1'b0;
      act_data_q   <= '0;
      act_dot_q    <= '0;
      act_hex_q    <= 1'b0;
      blank_q      <= '0;
      shown_q      <= 1'b0;
      seg_q        <= SEG_OFF;
      an_q         <= '1;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pend_valid_q <= pend_valid_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      if (bus.load) begin
        pend_data_q <= bus.data_in;
        pend_dot_q  <= bus.dot_in;
        pend_hex_q  <= bus.hex_mode;
      end
      if (commit) begin
        act_data_q <= act_data_d;
        act_dot_q  <= act_dot_d;
        act_hex_q  <= act_hex_d;
        blank_q    <= blank_d;
        shown_q    <= 1'b1;
      end
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = wrap;
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed checks of blanking, commit timing, glyphs, bypass and reset for seg_scan_driver.
module tb_seg_scan_driver;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic [7:0] seg;
  logic [3:0] an;
  logic       frame_done;
  int         n_chk = 0, n_fail = 0, pos = 0;

`ifdef SEG_LZ_SUPPRESS_EN
  localparam logic [7:0] LZ = 8'hFF;
`else
  localparam logic [7:0] LZ = 8'hC0;
`endif

  seg_scan_driver_if #(.DIGITS(4)) bus ();
  seg_scan_driver #(.DIGITS(4), .CLK_DIV(8), .DEAD(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .seg(seg), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_fd();
    int t = 0;
    @(negedge clk);
    while (frame_done !== 1'b1 && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (frame_done !== 1'b1) check("fd_timeout", 0, 1);
    pos = 0;
  endtask

  task automatic at(input int n);
    while (pos < n) begin
      @(negedge clk);
      pos++;
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dt, input logic hx);
    bus.load = 1'b1; bus.data_in = d; bus.dot_in = dt; bus.hex_mode = hx;
    @(negedge clk);
    pos++;
    bus.load = 1'b0;
  endtask

  // outputs for slot s, prescaler 2 appear 8*s+4 negedges after the frame_done sample
  task automatic slot(input string tag, input int s, input logic [7:0] eseg);
    logic [3:0] ea;
    ea = ~(4'b1 << s);
    at(8 * s + 4);
    check({tag, "_an"}, an, ea);
    check({tag, "_seg"}, seg, eseg);
  endtask

  task automatic blank_run(input string tag, input int cycles);
    int bad = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (an !== 4'hF || seg !== 8'hFF) bad++;
    end
    check(tag, bad, 0);
  endtask

  initial begin
    int c;
    bus.load = 1'b0; bus.data_in = '0; bus.dot_in = '0; bus.hex_mode = 1'b0;
    #12;
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 8'hFF);
    check("rst_fd", frame_done, 0);
    @(negedge clk) rst_n = 1'b1;

    wait_fd();
    at(1);
    check("fd_width", frame_done, 0);
    c = 1;
    while (frame_done !== 1'b1 && c < 64) begin
      @(negedge clk);
      c++;
    end
    check("fd_period", c, 32);
    blank_run("blank_3frames", 96);

    wait_fd();
    at(3);
    do_load(16'h1234, 4'b0010, 1'b0);
    wait_fd();
    at(3);  check("dead0_an", an, 4'hF);
    at(4);  check("lit0_an", an, 4'hE);
            check("lit0_seg", seg, 8'h99);
    at(9);  check("tail0_an", an, 4'hE);
    at(10); check("dead1_an", an, 4'hF);
            check("dead1_seg", seg, 8'hFF);
    slot("d1", 1, 8'h30);
    slot("d2", 2, 8'hA4);
    slot("d3", 3, 8'hF9);

    wait_fd();
    at(2);
    do_load(16'h1111, 4'b0000, 1'b0);
    at(5);
    do_load(16'h2222, 4'b0000, 1'b0);
    wait_fd();
    slot("lastw0", 0, 8'hA4);
    slot("lastw3", 3, 8'hA4);

    wait_fd();
    do_load(16'h5678, 4'b0000, 1'b0);
    slot("byp0", 0, 8'h80);
    slot("byp3", 3, 8'h92);

    wait_fd();
    do_load(16'hABEF, 4'b0000, 1'b1);
    bus.hex_mode = 1'b0;
    slot("hex0", 0, 8'h8E);
    slot("hex1", 1, 8'h86);
    slot("hex2", 2, 8'h83);
    slot("hex3", 3, 8'h88);

    wait_fd();
    do_load(16'hABEF, 4'b0000, 1'b0);
    slot("dec0", 0, 8'hC0);
    slot("dec1", 1, 8'hC0);
    slot("dec2", 2, 8'hFF);
    slot("dec3", 3, 8'hBF);

    wait_fd();
    do_load(16'h0050, 4'b0000, 1'b0);
    slot("lz0", 0, 8'hC0);
    slot("lz1", 1, 8'h92);
    slot("lz2", 2, LZ);
    slot("lz3", 3, LZ);

    wait_fd();
    at(2);
    do_load(16'h1234, 4'b0010, 1'b0);
    slot("prerst", 2, LZ);
    #2 rst_n = 1'b0;
    #1;
    check("arst_an", an, 4'hF);
    check("arst_seg", seg, 8'hFF);
    check("arst_fd", frame_done, 0);
    @(negedge clk) rst_n = 1'b1;
    blank_run("blank_after_rst", 100);

    wait_fd();
    do_load(16'h0007, 4'b0001, 1'b0);
    slot("reload0", 0, 8'h78);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
